// File: rtl/pps_pkg.sv
// pps_pkg: shared definitions for the PPS monitor slice.
// Holds the monitor state encoding, counter geometry, PPS source select
// constants and the elaboration-time parameter bound checks.
package pps_pkg;

    // Monitor state machine encoding.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } pps_state_t;

    // Period counter geometry.
    localparam int                   PPS_CNT_W   = 26;
    localparam logic [PPS_CNT_W-1:0] PPS_CNT_MAX = {PPS_CNT_W{1'b1}};

    // Error counter geometry.
    localparam int           PPS_ERR_W   = 16;
    localparam logic [15:0]  PPS_ERR_MAX = 16'hFFFF;

    // PPS source select constants shared with the clocking block.
    localparam logic [1:0] PPS_SEL_INTERNAL_10M = 2'd0;
    localparam logic [1:0] PPS_SEL_INTERNAL_25M = 2'd1;
    localparam logic [1:0] PPS_SEL_EXTERNAL     = 2'd2;
    localparam logic [1:0] PPS_SEL_GPSDO        = 2'd3;

    // good_cnt is 4 bits wide, so the lock threshold must fit in 1..15.
    function automatic logic lock_count_legal(input int lock_count);
        return (lock_count >= 1) && (lock_count <= 15);
    endfunction

    // The acceptance window must sit above zero and the timeout value
    // (CLK_FREQ+TOLERANCE+1) must be reachable before the counter saturates.
    function automatic logic tolerance_legal(input int clk_freq, input int tolerance);
        return (tolerance >= 0) && (tolerance < clk_freq) &&
               (longint'(clk_freq) + longint'(tolerance) + 1 < longint'(PPS_CNT_MAX));
    endfunction

endpackage

// File: rtl/pps_period_counter.sv
// pps_period_counter: PPS rising-edge detector plus free-running period counter.
// Latency: o_edge/o_timeout are combinational from i_pps and registered history.
// Backpressure: none; the PPS stream cannot be stalled.
// Ports: i_clk/i_rst clock and async active-high reset, i_pps synchronous PPS
// level, o_edge rising-edge flag, o_cnt cycles since last edge, o_timeout
// one-cycle flag when o_cnt hits TIMEOUT_CNT with no edge present.
module pps_period_counter
    import pps_pkg::*;
#(
    parameter int TIMEOUT_CNT = 103
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pps,
    output logic                 o_edge,
    output logic [PPS_CNT_W-1:0] o_cnt,
    output logic                 o_timeout
);

    localparam logic [PPS_CNT_W-1:0] TIMEOUT_VAL = PPS_CNT_W'(TIMEOUT_CNT);

    logic                 r_pps_d;
    logic [PPS_CNT_W-1:0] r_cnt;
    logic                 w_edge;

    assign w_edge = i_pps & ~r_pps_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pps_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pps_d <= i_pps;
            // Edge restarts the count at 1 so the value seen in the next edge
            // cycle equals the period in cycles.
            if (w_edge) begin
                r_cnt <= PPS_CNT_W'(1);
            end else if (r_cnt != PPS_CNT_MAX) begin
                r_cnt <= r_cnt + PPS_CNT_W'(1);
            end
        end
    end

    // The counter passes TIMEOUT_VAL only once per gap (it saturates far
    // above it), so this fires at most once between edges.
    assign o_timeout = (r_cnt == TIMEOUT_VAL) && !w_edge;
    assign o_edge    = w_edge;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/x4xx_pps_monitor.sv
// x4xx_pps_monitor: measures PPS period, tracks lock and counts PPS faults.
// Latency: all outputs registered, one cycle after the PPS edge/timeout cycle.
// Backpressure: none; events are reported as strobes and cannot be stalled.
// Ports: base_ref_clk/brc_rst clock and async active-high reset; pps_in PPS
// level (synchronous); clear_errors strobe; pps_pulse per-edge pulse; period/
// period_valid last measured period and update strobe; locked/lost state
// flags; error_count saturating fault count.
module x4xx_pps_monitor
    import pps_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int TOLERANCE  = 100,
    parameter int LOCK_COUNT = 3
) (
    input  logic                 base_ref_clk,
    input  logic                 brc_rst,
    input  logic                 pps_in,
    input  logic                 clear_errors,
    output logic                 pps_pulse,
    output logic [PPS_CNT_W-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 lost,
    output logic [PPS_ERR_W-1:0] error_count
);

    generate
        if (!lock_count_legal(LOCK_COUNT)) begin : g_bad_lock_count
            $error("x4xx_pps_monitor: LOCK_COUNT must be 1..15");
        end
        if (!tolerance_legal(CLK_FREQ, TOLERANCE)) begin : g_bad_tolerance
            $error("x4xx_pps_monitor: TOLERANCE out of range for CLK_FREQ");
        end
    endgenerate

    localparam logic [PPS_CNT_W-1:0] PER_MIN  = PPS_CNT_W'(CLK_FREQ - TOLERANCE);
    localparam logic [PPS_CNT_W-1:0] PER_MAX  = PPS_CNT_W'(CLK_FREQ + TOLERANCE);
    localparam logic [3:0]           LOCK_THR = 4'(LOCK_COUNT);

    logic                 w_edge;
    logic                 w_timeout;
    logic [PPS_CNT_W-1:0] w_cnt;
    logic                 w_good;
    logic [3:0]           w_good_cnt_inc;

    pps_state_t           r_state;
    pps_state_t           w_state_nxt;
    logic [3:0]           r_good_cnt;
    logic [3:0]           w_good_cnt_nxt;
    logic                 w_err_inc;
    logic                 w_report;

    logic                 r_pps_pulse;
    logic [PPS_CNT_W-1:0] r_period;
    logic                 r_period_valid;
    logic                 r_locked;
    logic                 r_lost;
    logic [PPS_ERR_W-1:0] r_error_count;

    pps_period_counter #(
        .TIMEOUT_CNT (CLK_FREQ + TOLERANCE + 1)
    ) u_period_counter (
        .i_clk     (base_ref_clk),
        .i_rst     (brc_rst),
        .i_pps     (pps_in),
        .o_edge    (w_edge),
        .o_cnt     (w_cnt),
        .o_timeout (w_timeout)
    );

    assign w_good         = (w_cnt >= PER_MIN) && (w_cnt <= PER_MAX);
    assign w_good_cnt_inc = r_good_cnt + 4'd1;

    always_ff @(posedge base_ref_clk or posedge brc_rst) begin
        if (brc_rst) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    // An edge landing exactly on the timeout cycle suppresses w_timeout in
    // the counter, so it is scored purely as a bad period (one error, no LOST).
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err_inc      = 1'b0;
        w_report       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_edge) begin
                    w_state_nxt    = ST_MEASURE;
                    w_good_cnt_nxt = 4'd0;
                end
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    w_report = 1'b1;
                    if (w_good) begin
                        w_good_cnt_nxt = w_good_cnt_inc;
                        if (w_good_cnt_inc == LOCK_THR) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_good_cnt_nxt = 4'd0;
                        w_err_inc      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOST;
                    w_err_inc   = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    w_report = 1'b1;
                    if (!w_good) begin
                        w_state_nxt    = ST_MEASURE;
                        w_good_cnt_nxt = 4'd0;
                        w_err_inc      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOST;
                    w_err_inc   = 1'b1;
                end
            end
            ST_LOST: begin
                // The first edge after a loss only re-establishes phase; its
                // period spans the outage and is neither reported nor scored.
                if (w_edge) begin
                    w_state_nxt    = ST_MEASURE;
                    w_good_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt    = ST_SEARCH;
                w_good_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Output registers: state flags decode the next state so they appear in
    // the same cycle as the state register update.
    always_ff @(posedge base_ref_clk or posedge brc_rst) begin
        if (brc_rst) begin
            r_pps_pulse    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_lost         <= 1'b0;
        end else begin
            r_pps_pulse    <= w_edge;
            r_period_valid <= w_report;
            if (w_report) begin
                r_period <= w_cnt;
            end
            r_locked <= (w_state_nxt == ST_LOCKED);
            r_lost   <= (w_state_nxt == ST_LOST);
        end
    end

    always_ff @(posedge base_ref_clk or posedge brc_rst) begin
        if (brc_rst) begin
            r_error_count <= '0;
        end else if (clear_errors) begin
            r_error_count <= '0;
        end else if (w_err_inc && (r_error_count != PPS_ERR_MAX)) begin
            r_error_count <= r_error_count + PPS_ERR_W'(1);
        end
    end

    assign pps_pulse    = r_pps_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign lost         = r_lost;
    assign error_count  = r_error_count;

endmodule

// File: tb/tb_x4xx_pps_monitor.sv
// tb_x4xx_pps_monitor: directed bench for the PPS monitor with
// CLK_FREQ=100, TOLERANCE=2, LOCK_COUNT=3. Inputs change and outputs are
// sampled on the falling edge of the clock.
module tb_x4xx_pps_monitor;

    logic        clk = 1'b0;
    logic        brc_rst;
    logic        pps_in;
    logic        clear_errors;
    logic        pps_pulse;
    logic [25:0] period;
    logic        period_valid;
    logic        locked;
    logic        lost;
    logic [15:0] error_count;

    int n_checks = 0;
    int n_errors = 0;

    // Snapshot of outputs taken one cycle after each driven PPS edge.
    logic        s_pulse;
    logic        s_pv;
    logic [25:0] s_period;
    logic        s_locked;
    logic        s_lost;
    logic [15:0] s_err;

    always #5 clk = ~clk;

    x4xx_pps_monitor #(
        .CLK_FREQ   (100),
        .TOLERANCE  (2),
        .LOCK_COUNT (3)
    ) dut (
        .base_ref_clk (clk),
        .brc_rst      (brc_rst),
        .pps_in       (pps_in),
        .clear_errors (clear_errors),
        .pps_pulse    (pps_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost),
        .error_count  (error_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a rising edge at the current falling edge and keep the next edge
    // n cycles away (so the period measured by the next edge is n). Outputs
    // are captured one cycle after this edge. Optionally strobe clear_errors
    // in the edge cycle.
    task automatic pps_period(input int n, input logic clr_on_edge);
        int lowpt;
        lowpt = (n / 4 < 1) ? 1 : n / 4;
        pps_in       = 1'b1;
        clear_errors = clr_on_edge;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                s_pulse      = pps_pulse;
                s_pv         = period_valid;
                s_period     = period;
                s_locked     = locked;
                s_lost       = lost;
                s_err        = error_count;
                clear_errors = 1'b0;
            end
            if (i == lowpt) pps_in = 1'b0;
        end
    endtask

    task automatic check_snap(input string tag, input logic exp_pv, input int exp_period,
                              input logic exp_locked, input logic [15:0] exp_err);
        check({tag, ".pulse"},  32'(s_pulse),  32'd1);
        check({tag, ".pv"},     32'(s_pv),     32'(exp_pv));
        check({tag, ".period"}, 32'(s_period), 32'(exp_period));
        check({tag, ".locked"}, 32'(s_locked), 32'(exp_locked));
        check({tag, ".lost"},   32'(s_lost),   32'd0);
        check({tag, ".err"},    32'(s_err),    32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pulse"},  32'(pps_pulse),    32'd0);
        check({tag, ".pv"},     32'(period_valid), 32'd0);
        check({tag, ".period"}, 32'(period),       32'd0);
        check({tag, ".locked"}, 32'(locked),       32'd0);
        check({tag, ".lost"},   32'(lost),         32'd0);
        check({tag, ".err"},    32'(error_count),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        brc_rst      = 1'b1;
        pps_in       = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        brc_rst = 1'b0;
        repeat (3) @(negedge clk);

        // Acquire lock with 100-cycle periods: lock after the 4th edge.
        pps_period(100, 1'b0); check_snap("e1", 1'b0, 0,   1'b0, 16'd0);
        pps_period(100, 1'b0); check_snap("e2", 1'b1, 100, 1'b0, 16'd0);
        pps_period(100, 1'b0); check_snap("e3", 1'b1, 100, 1'b0, 16'd0);
        pps_period(100, 1'b0); check_snap("e4", 1'b1, 100, 1'b1, 16'd0);
        // Short gap of 97 while locked drops lock, then relock.
        pps_period(97,  1'b0); check_snap("e5", 1'b1, 100, 1'b1, 16'd0);
        pps_period(100, 1'b0); check_snap("e6", 1'b1, 97,  1'b0, 16'd1);
        pps_period(100, 1'b0); check_snap("e7", 1'b1, 100, 1'b0, 16'd1);
        pps_period(100, 1'b0); check_snap("e8", 1'b1, 100, 1'b0, 16'd1);
        pps_period(101, 1'b0); check_snap("e9", 1'b1, 100, 1'b1, 16'd1);

        // Missing PPS while locked: lost one cycle after cnt reaches 103.
        pps_period(103, 1'b0); check_snap("e10", 1'b1, 101, 1'b1, 16'd1);
        check("to.lost_at_103", 32'(lost), 32'd0);
        @(negedge clk);
        check("to.lost_at_104",   32'(lost),        32'd1);
        check("to.locked_at_104", 32'(locked),      32'd0);
        check("to.err_at_104",    32'(error_count), 32'd2);

        // Edge after loss: back to MEASURE, period not reported.
        pps_period(100, 1'b0); check_snap("e11", 1'b0, 101, 1'b0, 16'd2);
        pps_period(100, 1'b0); check_snap("e12", 1'b1, 100, 1'b0, 16'd2);
        pps_period(100, 1'b0); check_snap("e13", 1'b1, 100, 1'b0, 16'd2);
        // Next edge lands exactly in the timeout cycle (cnt=103).
        pps_period(103, 1'b0); check_snap("e14", 1'b1, 100, 1'b1, 16'd2);
        pps_period(50,  1'b0); check_snap("e15", 1'b1, 103, 1'b0, 16'd3);

        // clear_errors coincident with a bad edge wins.
        pps_period(40,  1'b1); check_snap("e16", 1'b1, 50,  1'b0, 16'd0);

        // Preload near saturation, then two more bad edges.
        force dut.r_error_count = 16'hFFFE;
        #1;
        release dut.r_error_count;
        pps_period(40,  1'b0); check_snap("e17", 1'b1, 40,  1'b0, 16'hFFFF);
        pps_period(99,  1'b0); check_snap("e18", 1'b1, 40,  1'b0, 16'hFFFF);

        // Standalone clear strobe.
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        check("clr.err", 32'(error_count), 32'd0);

        // Relock, then reset at cnt=50.
        pps_period(100, 1'b0); check_snap("e19", 1'b1, 100, 1'b0, 16'd0);
        pps_period(100, 1'b0); check_snap("e20", 1'b1, 100, 1'b0, 16'd0);
        pps_period(50,  1'b0); check_snap("e21", 1'b1, 100, 1'b1, 16'd0);
        brc_rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        brc_rst = 1'b0;
        repeat (2) @(negedge clk);
        pps_period(100, 1'b0); check_snap("e22", 1'b0, 0,   1'b0, 16'd0);
        pps_period(100, 1'b0); check_snap("e23", 1'b1, 100, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/x4xx_pps_monitor.md
X4XX_PPS_MONITOR -- requirements
Module: x4xx_pps_monitor

Interface
REQ-001 Parameter CLK_FREQ, default 10_000_000: expected PPS period in base_ref_clk cycles.
REQ-002 Parameter TOLERANCE, default 100: allowed period deviation in cycles, either direction.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good periods required to declare lock; legal range 1 to 15.
REQ-004 base_ref_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 brc_rst  input  1  reset; asynchronous and active-high.
REQ-006 pps_in  input  1  PPS level, already synchronous to base_ref_clk (25% duty).
REQ-007 clear_errors  input  1  single-cycle strobe that zeroes error_count.
REQ-008 pps_pulse  output  1  one-cycle pulse per detected PPS rising edge.
REQ-009 period  output  26  last measured PPS period in cycles.
REQ-010 period_valid  output  1  one-cycle strobe when period is updated.
REQ-011 locked  output  1  high while the state is LOCKED.
REQ-012 lost  output  1  high while the state is LOST.
REQ-013 error_count  output  16  saturating count of bad or missing PPS events.

Function
REQ-014 Edge detect: edge = pps_in AND NOT pps_in registered one cycle earlier.
REQ-015 pps_pulse asserts exactly one cycle, in the cycle after edge is true.
REQ-016 Cycle counter cnt (26 bit): loads 1 on edge; otherwise increments; saturates at 2^26-1.
REQ-017 Measured period = cnt value in the edge cycle; good when CLK_FREQ-TOLERANCE <= value <= CLK_FREQ+TOLERANCE, else bad.
REQ-018 Timeout: cnt equals CLK_FREQ+TOLERANCE+1 with no edge in that cycle; fires once per gap.
REQ-019 States: SEARCH, MEASURE, LOCKED, LOST; a 4-bit good_cnt tracks consecutive good periods.
REQ-020 SEARCH: edge -> MEASURE, good_cnt=0; no period reported; timeout ignored.
REQ-021 MEASURE: good edge -> good_cnt+1, and when good_cnt+1 equals LOCK_COUNT -> LOCKED; bad edge -> good_cnt=0, error+1; timeout -> LOST, error+1.
REQ-022 LOCKED: good edge -> stay; bad edge -> MEASURE, good_cnt=0, error+1; timeout -> LOST, error+1.
REQ-023 LOST: edge -> MEASURE, good_cnt=0; that edge's period is not reported and not scored.
REQ-024 In MEASURE and LOCKED, each edge updates period and pulses period_valid one cycle after the edge, coincident with pps_pulse.
REQ-025 An edge in the exact timeout cycle counts as a bad period, with one error only and no transition to LOST.
REQ-026 error_count saturates at 16'hFFFF; clear_errors wins over a simultaneous increment; it takes effect on the next cycle.
REQ-027 locked and lost are registered decodes of the state, valid one cycle after the transition.

Reset
REQ-028 brc_rst asynchronously forces state=SEARCH, cnt=0, good_cnt=0, period=0, error_count=0, edge history=0, and all outputs low.
REQ-029 Reset asserted mid-measurement discards the partial period; after release, the first edge is treated as in SEARCH.

Structure
REQ-030 State encoding and the LOCK_COUNT/TOLERANCE bound checks live in a shared pps_pkg package with the PPS select constants.
REQ-031 Edge detector plus period counter form one sub-module, pps_period_counter; the state machine and error logic stay in the top level.

Verification (CLK_FREQ=100, TOLERANCE=2, LOCK_COUNT=3)
REQ-032 Edges every 100 cycles -> locked rises 1 cycle after the 4th edge; period=100; error_count=0.
REQ-033 While locked, one gap of 97 cycles -> locked falls, error_count=1, period=97; 3 further 100-cycle periods -> relock.
REQ-034 While locked, pps_in held low -> lost asserts 1 cycle after cnt reaches 103; error_count=1; the next edge -> MEASURE with no period_valid.
REQ-035 Edge exactly at cnt=103 -> error_count+1 once, state MEASURE, lost stays low.
REQ-036 clear_errors in the same cycle as a bad edge -> error_count=0; error_count pre-loaded to FFFF by a long fault stream stays at FFFF.
REQ-037 brc_rst pulsed at cnt=50 while locked -> all outputs 0 immediately; the following edge produces no period_valid.
